// File: rtl/store_align_buffer_if.sv
// -----------------------------------------------------------------------------
// store_align_buffer_if
// Purpose : bundles the MEM-stage store request, the Data Memory drain port and
//           the misalignment report of store_align_buffer.
// Optional: STORE_FWD_EN adds the load-hazard probe (ld_valid, ld_addr, ld_hit).
// Signals :
//   st_valid/st_type/st_addr/st_data  store request from the MEM stage
//   st_ready                          buffer can take a request (!full)
//   mem_req/mem_addr/mem_be/mem_wdata head entry toward Data Memory
//   mem_ack                           Data Memory took the head entry
//   misalign/misalign_addr            rejected misaligned store report
//   empty                             buffer holds no entries
// Modports: master = MEM stage + Data Memory side, slave = the buffer.
// -----------------------------------------------------------------------------
interface store_align_buffer_if;
    logic        st_valid;
    logic [1:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        misalign;
    logic [31:0] misalign_addr;
    logic        empty;
`ifdef STORE_FWD_EN
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
`endif

    modport master (
`ifdef STORE_FWD_EN
        output ld_valid, output ld_addr, input ld_hit,
`endif
        output st_valid, output st_type, output st_addr, output st_data,
        input  st_ready,
        input  mem_req, input mem_addr, input mem_be, input mem_wdata,
        output mem_ack,
        input  misalign, input misalign_addr, input empty
    );

    modport slave (
`ifdef STORE_FWD_EN
        input  ld_valid, input ld_addr, output ld_hit,
`endif
        input  st_valid, input st_type, input st_addr, input st_data,
        output st_ready,
        output mem_req, output mem_addr, output mem_be, output mem_wdata,
        input  mem_ack,
        output misalign, output misalign_addr, output empty
    );
endinterface

// File: rtl/store_align_buffer.sv
// -----------------------------------------------------------------------------
// store_align_buffer
// Purpose : turns SB/SH/SW requests into word address + byte enables + lane
//           shifted data, queues them in a DEPTH-entry FIFO and drains them to
//           the word-addressed Data Memory. Misaligned SH/SW are rejected and
//           reported through a one-cycle misalign pulse.
// Optional: define STORE_FWD_EN to add the ld_valid/ld_addr/ld_hit hazard probe.
// Ports   :
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  store_align_buffer_if.slave (request, drain, misalign, empty)
// Handshakes:
//   request side - a request is taken on a rising edge where st_valid and
//   st_ready are both 1 (and it is a valid, aligned store); st_ready does not
//   depend on st_valid.
//   drain side   - mem_req is held with stable addr/be/wdata until a rising
//   edge where mem_req and mem_ack are both 1; that edge pops the head.
// -----------------------------------------------------------------------------
module store_align_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    store_align_buffer_if.slave  bus
);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [29:0]      r_addr_mem [DEPTH];
    logic [3:0]       r_be_mem   [DEPTH];
    logic [31:0]      r_data_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_misalign;
    logic [31:0]      r_misalign_addr;

    logic             w_full;
    logic             w_empty;
    logic             w_evaluate;
    logic             w_aligned;
    logic             w_push;
    logic             w_pop;
    logic             w_reject;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

    // Lane generation. Unused lanes carry replicated data; be masks them.
    always_comb begin
        w_aligned = 1'b0;
        w_be      = 4'b0000;
        w_wdata   = bus.st_data;
        case (bus.st_type)
            2'b01: begin
                w_aligned = 1'b1;
                w_be      = 4'b0001 << bus.st_addr[1:0];
                w_wdata   = {4{bus.st_data[7:0]}};
            end
            2'b10: begin
                w_aligned = ~bus.st_addr[0];
                w_be      = 4'b0011 << bus.st_addr[1:0];
                w_wdata   = {2{bus.st_data[15:0]}};
            end
            2'b11: begin
                w_aligned = (bus.st_addr[1:0] == 2'b00);
                w_be      = 4'b1111;
                w_wdata   = bus.st_data;
            end
            default: begin
                w_aligned = 1'b0;
            end
        endcase
    end

    // A request is only looked at when the buffer can take it; a request
    // presented while full is neither pushed nor reported.
    assign w_evaluate = bus.st_valid && !w_full && (bus.st_type != 2'b00);
    assign w_push     = w_evaluate && w_aligned;
    assign w_reject   = w_evaluate && !w_aligned;
    assign w_pop      = !w_empty && bus.mem_ack;

    // Entry storage needs no reset: contents are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_wr_ptr] <= bus.st_addr[31:2];
            r_be_mem[r_wr_ptr]   <= w_be;
            r_data_mem[r_wr_ptr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_misalign <= w_reject;
            if (w_reject) begin
                r_misalign_addr <= bus.st_addr;
            end
        end
    end

    assign bus.st_ready      = !w_full;
    assign bus.empty         = w_empty;
    assign bus.mem_req       = !w_empty;
    assign bus.mem_addr      = w_empty ? 32'h0 : {r_addr_mem[r_rd_ptr], 2'b00};
    assign bus.mem_be        = w_empty ? 4'h0  : r_be_mem[r_rd_ptr];
    assign bus.mem_wdata     = w_empty ? 32'h0 : r_data_mem[r_rd_ptr];
    assign bus.misalign      = r_misalign;
    assign bus.misalign_addr = r_misalign_addr;

`ifdef STORE_FWD_EN
    logic w_ld_hit;

    // Slot i is live when its distance from the read pointer is below count.
    // Any live word match stalls the load, whatever its byte enables.
    always_comb begin
        w_ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.ld_valid
                && ({1'b0, PTR_W'(PTR_W'(i) - r_rd_ptr)} < r_count)
                && (r_addr_mem[i] == bus.ld_addr[31:2])) begin
                w_ld_hit = 1'b1;
            end
        end
    end

    assign bus.ld_hit = w_ld_hit;
`endif
endmodule

// File: tb/tb_store_align_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_align_buffer
// Directed bench for store_align_buffer (DEPTH=4). Expected memory writes are
// pushed into exp_q when a store is issued; a monitor pops and compares on every
// negedge where mem_req && mem_ack. Status outputs are checked directly.
// -----------------------------------------------------------------------------
module tb_store_align_buffer;
    logic clk = 1'b0;
    logic rst;

    store_align_buffer_if bus();

    store_align_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [67:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [67:0] e;
        if (rst === 1'b0 && bus.mem_req === 1'b1 && bus.mem_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%08h expected no write", bus.mem_addr);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", bus.mem_addr, e[67:36]);
                check("write_be", {28'h0, bus.mem_be}, {28'h0, e[35:32]});
                check("write_data", bus.mem_wdata, e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        bus.st_valid = 1'b1;
        bus.st_type  = t;
        bus.st_addr  = a;
        bus.st_data  = d;
    endtask

    task automatic idle();
        bus.st_valid = 1'b0;
        bus.st_type  = 2'b00;
        bus.st_addr  = 32'h0;
        bus.st_data  = 32'h0;
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        exp_q.push_back({a, be, d});
    endtask

    // One-cycle request.
    task automatic store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        drive(t, a, d);
        cyc();
        idle();
    endtask

    // Holds the request until st_ready lets it through, then records the write.
    task automatic store_wait(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ed);
        bit ok;
        ok = 1'b0;
        drive(t, a, d);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.st_ready === 1'b1) begin
                cyc();
                ok = 1'b1;
                break;
            end
        end
        idle();
        if (ok) begin
            expect_write(ea, ebe, ed);
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL st_ready_timeout: got st_ready=0 expected 1 within 20 cycles");
        end
    endtask

    task automatic wait_empty();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.empty === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check1("drain_to_empty", ok, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  b;
        logic [15:0] h;

        rst          = 1'b1;
        bus.mem_ack  = 1'b0;
`ifdef STORE_FWD_EN
        bus.ld_valid = 1'b0;
        bus.ld_addr  = 32'h0;
`endif
        idle();

        // Reset state.
        repeat (2) @(negedge clk);
        check1("rst_mem_req", bus.mem_req, 1'b0);
        check1("rst_empty", bus.empty, 1'b1);
        check1("rst_st_ready", bus.st_ready, 1'b1);
        check1("rst_misalign", bus.misalign, 1'b0);
        check("rst_misalign_addr", bus.misalign_addr, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        cyc();
        rst = 1'b0;
        cyc();

        // SB 0xAB @0x103: no bypass, lane 3, replicated byte.
        drive(2'b01, 32'h0000_0103, 32'h0000_00AB);
        @(negedge clk);
        check1("sb_no_bypass", bus.mem_req, 1'b0);
        cyc();
        idle();
        expect_write(32'h0000_0100, 4'b1000, 32'hABAB_ABAB);
        @(negedge clk);
        check1("sb_mem_req", bus.mem_req, 1'b1);
        check("sb_mem_be", {28'h0, bus.mem_be}, 32'h8);
        cyc();
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check1("sb_empty_after_ack", bus.empty, 1'b1);
        check("sb_idle_addr", bus.mem_addr, 32'h0);

        // SH @0x202 then SW @0x204, head held while mem_ack=0.
        store(2'b10, 32'h0000_0202, 32'h0000_1234);
        expect_write(32'h0000_0200, 4'b1100, 32'h1234_1234);
        store(2'b11, 32'h0000_0204, 32'hDEAD_BEEF);
        expect_write(32'h0000_0204, 4'b1111, 32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("sh_hold_addr", bus.mem_addr, 32'h0000_0200);
            check("sh_hold_be", {28'h0, bus.mem_be}, 32'hC);
            check("sh_hold_data", bus.mem_wdata, 32'h1234_1234);
        end
        cyc();
        bus.mem_ack = 1'b1;
        cyc();
        cyc();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check1("sh_sw_drained", bus.empty, 1'b1);

        // Misaligned SW and SH; st_type 00 does nothing.
        store(2'b11, 32'h0000_0101, 32'h1111_1111);
        @(negedge clk);
        check1("mis_sw_pulse", bus.misalign, 1'b1);
        check("mis_sw_addr", bus.misalign_addr, 32'h0000_0101);
        check1("mis_sw_no_push", bus.empty, 1'b1);
        @(negedge clk);
        check1("mis_sw_one_cycle", bus.misalign, 1'b0);
        check("mis_sw_addr_hold", bus.misalign_addr, 32'h0000_0101);
        store(2'b10, 32'h0000_0003, 32'h0000_2222);
        @(negedge clk);
        check1("mis_sh_pulse", bus.misalign, 1'b1);
        check("mis_sh_addr", bus.misalign_addr, 32'h0000_0003);
        store(2'b00, 32'h0000_0700, 32'h3333_3333);
        @(negedge clk);
        check1("none_no_push", bus.empty, 1'b1);
        check1("none_no_misalign", bus.misalign, 1'b0);

        // Fill four SB stores, full behaviour, pop then accept.
        store(2'b01, 32'h0000_0010, 32'h0000_00C0);
        expect_write(32'h0000_0010, 4'b0001, 32'hC0C0_C0C0);
        store(2'b01, 32'h0000_0011, 32'h0000_00C1);
        expect_write(32'h0000_0010, 4'b0010, 32'hC1C1_C1C1);
        store(2'b01, 32'h0000_0012, 32'h0000_00C2);
        expect_write(32'h0000_0010, 4'b0100, 32'hC2C2_C2C2);
        store(2'b01, 32'h0000_0013, 32'h0000_00C3);
        expect_write(32'h0000_0010, 4'b1000, 32'hC3C3_C3C3);
        @(negedge clk);
        check1("full_st_ready", bus.st_ready, 1'b0);
        store(2'b11, 32'h0000_0555, 32'h4444_4444);
        @(negedge clk);
        check1("full_mis_ignored", bus.misalign, 1'b0);
        check("full_mis_addr_hold", bus.misalign_addr, 32'h0000_0003);
        drive(2'b01, 32'h0000_0020, 32'h0000_0055);
        @(negedge clk);
        check1("full_5th_blocked", bus.st_ready, 1'b0);
        cyc();
        bus.mem_ack = 1'b1;
        @(negedge clk);
        check1("full_pop_cycle", bus.st_ready, 1'b0);
        cyc();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check1("after_pop_ready", bus.st_ready, 1'b1);
        cyc();
        idle();
        expect_write(32'h0000_0020, 4'b0001, 32'h5555_5555);
        @(negedge clk);
        check1("refull_st_ready", bus.st_ready, 0);

        // Twelve mixed stores with continuous ack: order across pointer wrap.
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 12; i++) begin
            b = 8'hF0 + 8'(i);
            h = 16'hBEE0 + 16'(i);
            case (i % 3)
                0: store_wait(2'b11, 32'h300 + 32'(8*i), 32'hA000_0000 + 32'(i),
                              32'h300 + 32'(8*i), 4'b1111, 32'hA000_0000 + 32'(i));
                1: store_wait(2'b01, 32'h302 + 32'(8*i), {24'h000001, b},
                              32'h300 + 32'(8*i), 4'b0100, {4{b}});
                default: store_wait(2'b10, 32'h302 + 32'(8*i), {16'h7777, h},
                                    32'h300 + 32'(8*i), 4'b1100, {2{h}});
            endcase
        end
        wait_empty();
        bus.mem_ack = 1'b0;
        check("wrap_queue_drained", 32'(exp_q.size()), 32'h0);

        // Asynchronous reset mid-drain with three entries queued.
        store(2'b11, 32'h0000_0500, 32'h0000_5000);
        store(2'b11, 32'h0000_0504, 32'h0000_5001);
        store(2'b11, 32'h0000_0508, 32'h0000_5002);
        @(negedge clk);
        check1("pre_rst_mem_req", bus.mem_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check1("arst_mem_req", bus.mem_req, 1'b0);
        check1("arst_empty", bus.empty, 1'b1);
        check1("arst_st_ready", bus.st_ready, 1'b1);
        check("arst_mem_be", {28'h0, bus.mem_be}, 32'h0);
        check("arst_misalign_addr", bus.misalign_addr, 32'h0);
        cyc();
        cyc();
        #2;
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check1("post_rst_no_write", bus.mem_req, 1'b0);
        end
        bus.mem_ack = 1'b0;

`ifdef STORE_FWD_EN
        // Load hazard probe.
        store(2'b11, 32'h0000_0400, 32'hCAFE_F00D);
        expect_write(32'h0000_0400, 4'b1111, 32'hCAFE_F00D);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h0000_0402;
        #1;
        check1("fwd_hit_same_word", bus.ld_hit, 1'b1);
        bus.ld_addr  = 32'h0000_0404;
        #1;
        check1("fwd_miss_next_word", bus.ld_hit, 1'b0);
        bus.ld_addr  = 32'h0000_0402;
        bus.ld_valid = 1'b0;
        #1;
        check1("fwd_no_valid", bus.ld_hit, 1'b0);
        cyc();
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack  = 1'b0;
        bus.ld_valid = 1'b1;
        #1;
        check1("fwd_after_drain", bus.ld_hit, 1'b0);
        bus.ld_valid = 1'b0;
`endif

        repeat (2) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
